// File: rtl/dbg_pkg.sv
// Shared types and address map for the debug access controller.
// Holds the FSM state encoding, the request bundle and the reserved addresses.
package dbg_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_GRANT  = 2'd1,
        ST_ACCESS = 2'd2,
        ST_RESP   = 2'd3
    } dbg_state_e;

    localparam logic [7:0] DBG_UNLOCK_ADDR = 8'hE0;
    localparam logic [7:0] DBG_RELOCK_ADDR = 8'hE1;
    localparam logic [3:0] DBG_PRIV_NIBBLE = 4'hF;

    typedef struct packed {
        logic        we;
        logic [7:0]  addr;
        logic [31:0] wdata;
    } dbg_req_t;

    function automatic logic is_priv(input logic [7:0] addr);
        return addr[7:4] == DBG_PRIV_NIBBLE;
    endfunction

endpackage

// File: rtl/dbg_rr_arb2.sv
// Two-way round-robin arbiter; the pointer names the preferred requester
// and flips after every accepted grant.
module dbg_rr_arb2 (
    input  logic       clk,
    input  logic       rst,
    input  logic [1:0] req_i,
    input  logic       adv_i,
    output logic       valid_o,
    output logic       id_o
);

    logic ptr_q;

    always_comb begin
        valid_o = |req_i;
        if (req_i == 2'b11) begin
            id_o = ptr_q;
        end else begin
            id_o = req_i[1];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ptr_q <= 1'b0;
        end else if (adv_i && valid_o) begin
            ptr_q <= ~ptr_q;
        end
    end

endmodule

// File: rtl/debug_access_ctrl.sv
// Debug register access controller: arbitrates m0/m1, gates privileged
// writes behind a key unlock with lockout/relock, and times target accesses.
//
// state     | meaning
// ST_IDLE   | waiting for a request, arbitration runs here
// ST_GRANT  | gnt pulse, fields latched, access classified
// ST_ACCESS | dbg_en held until dbg_ready or timeout
// ST_RESP   | rvalid pulse to the owner
module debug_access_ctrl
    import dbg_pkg::*;
#(
    parameter logic [31:0] UNLOCK_KEY     = 32'hA5C3_5A3C,
    parameter int unsigned MAX_FAIL       = 3,
    parameter int unsigned LOCKOUT_CYCLES = 1024,
    parameter int unsigned RELOCK_CYCLES  = 4096,
    parameter int unsigned TGT_TIMEOUT    = 16
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        m0_req,
    input  logic        m0_we,
    input  logic [7:0]  m0_addr,
    input  logic [31:0] m0_wdata,
    output logic        m0_gnt,
    output logic        m0_rvalid,
    output logic [31:0] m0_rdata,
    output logic        m0_err,
    input  logic        m1_req,
    input  logic        m1_we,
    input  logic [7:0]  m1_addr,
    input  logic [31:0] m1_wdata,
    output logic        m1_gnt,
    output logic        m1_rvalid,
    output logic [31:0] m1_rdata,
    output logic        m1_err,
    output logic        dbg_en,
    output logic        dbg_we,
    output logic [7:0]  dbg_addr,
    output logic [31:0] dbg_wdata,
    input  logic [31:0] dbg_rdata,
    input  logic        dbg_ready,
    output logic        unlocked,
    output logic        locked_out
);

    localparam int unsigned FAIL_W   = $clog2(MAX_FAIL + 1);
    localparam int unsigned LOCK_W   = $clog2(LOCKOUT_CYCLES + 1);
    localparam int unsigned RELOCK_W = $clog2(RELOCK_CYCLES + 1);
    localparam int unsigned TMO_W    = $clog2(TGT_TIMEOUT + 1);

    localparam logic [FAIL_W-1:0]   FAIL_LIMIT  = FAIL_W'(MAX_FAIL);
    localparam logic [LOCK_W-1:0]   LOCK_LOAD   = LOCK_W'(LOCKOUT_CYCLES);
    localparam logic [RELOCK_W-1:0] RELOCK_LOAD = RELOCK_W'(RELOCK_CYCLES);
    localparam logic [TMO_W-1:0]    TMO_LOAD    = TMO_W'(TGT_TIMEOUT);

    dbg_state_e            state_q, state_d;
    logic                  owner_q, owner_d;
    dbg_req_t              req_q, req_d;
    dbg_req_t              cur_req;
    logic [31:0]           rdata_q, rdata_d;
    logic                  err_q, err_d;
    logic                  unlocked_q, unlocked_d;
    logic                  locked_q, locked_d;
    logic [FAIL_W-1:0]     fail_cnt_q, fail_cnt_d, fail_inc;
    logic [LOCK_W-1:0]     lock_cnt_q, lock_cnt_d;
    logic [RELOCK_W-1:0]   relock_cnt_q, relock_cnt_d;
    logic [TMO_W-1:0]      tmo_cnt_q, tmo_cnt_d;
    logic                  arb_valid, arb_id;
    logic                  any_req;

    assign any_req = m0_req | m1_req;

    dbg_rr_arb2 u_arb (
        .clk     (clk),
        .rst     (rst),
        .req_i   ({m1_req, m0_req}),
        .adv_i   (state_q == ST_IDLE),
        .valid_o (arb_valid),
        .id_o    (arb_id)
    );

    // Requesters hold their fields until gnt, so the owner's live inputs are valid in GRANT.
    always_comb begin
        if (owner_q) begin
            cur_req.we    = m1_we;
            cur_req.addr  = m1_addr;
            cur_req.wdata = m1_wdata;
        end else begin
            cur_req.we    = m0_we;
            cur_req.addr  = m0_addr;
            cur_req.wdata = m0_wdata;
        end
    end

    always_comb begin
        state_d      = state_q;
        owner_d      = owner_q;
        req_d        = req_q;
        rdata_d      = rdata_q;
        err_d        = err_q;
        unlocked_d   = unlocked_q;
        locked_d     = locked_q;
        fail_cnt_d   = fail_cnt_q;
        lock_cnt_d   = lock_cnt_q;
        relock_cnt_d = relock_cnt_q;
        tmo_cnt_d    = tmo_cnt_q;
        fail_inc     = fail_cnt_q + 1'b1;

        if (locked_q) begin
            if (lock_cnt_q <= LOCK_W'(1)) begin
                locked_d   = 1'b0;
                fail_cnt_d = '0;
                lock_cnt_d = '0;
            end else begin
                lock_cnt_d = lock_cnt_q - 1'b1;
            end
        end

        // Relock only counts genuinely idle cycles; any grant reloads it below.
        if (unlocked_q && (state_q == ST_IDLE) && !any_req) begin
            if (relock_cnt_q <= RELOCK_W'(1)) begin
                unlocked_d   = 1'b0;
                relock_cnt_d = '0;
            end else begin
                relock_cnt_d = relock_cnt_q - 1'b1;
            end
        end

        case (state_q)
            ST_IDLE: begin
                if (arb_valid) begin
                    owner_d = arb_id;
                    state_d = ST_GRANT;
                end
            end
            ST_GRANT: begin
                req_d        = cur_req;
                relock_cnt_d = RELOCK_LOAD;
                tmo_cnt_d    = TMO_LOAD;
                rdata_d      = '0;
                err_d        = 1'b0;
                if (cur_req.we && (cur_req.addr == DBG_UNLOCK_ADDR)) begin
                    state_d = ST_RESP;
                    if (locked_q || owner_q) begin
                        err_d = 1'b1;
                    end else if (cur_req.wdata == UNLOCK_KEY) begin
                        unlocked_d = 1'b1;
                        fail_cnt_d = '0;
                    end else begin
                        err_d      = 1'b1;
                        fail_cnt_d = fail_inc;
                        if (fail_inc == FAIL_LIMIT) begin
                            locked_d   = 1'b1;
                            lock_cnt_d = LOCK_LOAD;
                        end
                    end
                end else if (cur_req.we && (cur_req.addr == DBG_RELOCK_ADDR)) begin
                    unlocked_d = 1'b0;
                    state_d    = ST_RESP;
                end else if (cur_req.we && is_priv(cur_req.addr) && (!unlocked_q || owner_q)) begin
                    err_d   = 1'b1;
                    state_d = ST_RESP;
                end else begin
                    state_d = ST_ACCESS;
                end
            end
            ST_ACCESS: begin
                // Ready on the final timeout cycle still counts as success.
                if (dbg_ready) begin
                    rdata_d = req_q.we ? 32'h0 : dbg_rdata;
                    err_d   = 1'b0;
                    state_d = ST_RESP;
                end else if (tmo_cnt_q <= TMO_W'(1)) begin
                    rdata_d = '0;
                    err_d   = 1'b1;
                    state_d = ST_RESP;
                end else begin
                    tmo_cnt_d = tmo_cnt_q - 1'b1;
                end
            end
            ST_RESP: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= ST_IDLE;
            owner_q      <= 1'b0;
            req_q        <= '0;
            rdata_q      <= '0;
            err_q        <= 1'b0;
            unlocked_q   <= 1'b0;
            locked_q     <= 1'b0;
            fail_cnt_q   <= '0;
            lock_cnt_q   <= '0;
            relock_cnt_q <= '0;
            tmo_cnt_q    <= '0;
        end else begin
            state_q      <= state_d;
            owner_q      <= owner_d;
            req_q        <= req_d;
            rdata_q      <= rdata_d;
            err_q        <= err_d;
            unlocked_q   <= unlocked_d;
            locked_q     <= locked_d;
            fail_cnt_q   <= fail_cnt_d;
            lock_cnt_q   <= lock_cnt_d;
            relock_cnt_q <= relock_cnt_d;
            tmo_cnt_q    <= tmo_cnt_d;
        end
    end

    assign m0_gnt    = (state_q == ST_GRANT) && !owner_q;
    assign m1_gnt    = (state_q == ST_GRANT) && owner_q;
    assign m0_rvalid = (state_q == ST_RESP) && !owner_q;
    assign m1_rvalid = (state_q == ST_RESP) && owner_q;
    assign m0_rdata  = m0_rvalid ? rdata_q : 32'h0;
    assign m1_rdata  = m1_rvalid ? rdata_q : 32'h0;
    assign m0_err    = m0_rvalid & err_q;
    assign m1_err    = m1_rvalid & err_q;

    assign dbg_en    = (state_q == ST_ACCESS);
    assign dbg_we    = dbg_en & req_q.we;
    assign dbg_addr  = dbg_en ? req_q.addr : 8'h0;
    assign dbg_wdata = dbg_en ? req_q.wdata : 32'h0;

    assign unlocked   = unlocked_q;
    assign locked_out = locked_q;

endmodule
